// File: rtl/led_pkg.sv
// led_pkg: shared mode/state encodings and default timing constants for the LED pattern engine.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_ROT_L = 2'd0,
      MODE_ROT_R = 2'd1,
      MODE_PING  = 2'd2,
      MODE_FILL  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_e;

   localparam int DEF_TICK_CNT = 100000000;
   localparam int DEF_DB_CNT   = 1000000;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser, DB_CNT-sample debouncer and one-cycle rising-edge press pulse.
module btn_debounce #(
   parameter int DB_CNT = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic press
);

   localparam int CW = DB_CNT > 1 ? $clog2(DB_CNT) : 1;

   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          db_q, db_d;
   logic          press_q, press_d;
   logic          flip;

   // cnt tracks how many consecutive synchronised samples disagree with the accepted level
   always_comb begin
      sync_d  = {sync_q[0], btn_in};
      flip    = sync_q[1] != db_q && cnt_q == CW'(DB_CNT - 1);
      cnt_d   = (sync_q[1] == db_q || flip) ? '0 : cnt_q + 1'b1;
      db_d    = flip ? sync_q[1] : db_q;
      press_d = db_d & ~db_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         db_q    <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         db_q    <= db_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/led_pattern_engine.sv
// led_pattern_engine: N-bit LED bank stepping through four patterns with debounced start/pause.
// Optional LED_PATTERN_SPEED_SEL_EN adds a speed port that divides the step period by 1/2/4/8.
module led_pattern_engine
   import led_pkg::*;
#(
   parameter int N_LEDS   = 8,
   parameter int TICK_CNT = DEF_TICK_CNT,
   parameter int DB_CNT   = DEF_DB_CNT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              button,
   input  logic [1:0]        mode,
`ifdef LED_PATTERN_SPEED_SEL_EN
   input  logic [1:0]        speed,
`endif
   output logic [N_LEDS-1:0] led,
   output logic              busy
);

   localparam int TW = $clog2(TICK_CNT);
   typedef logic [TW-1:0] tick_t;

   state_e            state_q, state_d;
   tick_t             tick_q, tick_d;
   logic [N_LEDS-1:0] led_q, led_d;
   mode_e             mode_q, mode_d;
   logic              dir_q, dir_d;
   logic [N_LEDS-1:0] nxt_led;
   logic              nxt_dir;
   mode_e             mode_in;
   tick_t             term;
   logic              step;
   logic              press;

   function automatic logic [N_LEDS-1:0] init_pat(mode_e m);
      return m == MODE_ROT_R ? {1'b1, {(N_LEDS-1){1'b0}}} : N_LEDS'(1);
   endfunction

   btn_debounce #(.DB_CNT(DB_CNT)) u_db (
      .clk    (clk),
      .rst    (rst),
      .btn_in (button),
      .press  (press)
   );

`ifdef LED_PATTERN_SPEED_SEL_EN
   tick_t term_q, term_d;

   function automatic tick_t last_tick(logic [1:0] s);
      int p;
      p = TICK_CNT >> s;
      return tick_t'((p > 1 ? p : 1) - 1);
   endfunction

   // speed is latched per step so a change never cuts short the step in flight
   always_comb term_d = (state_q == ST_IDLE || step) ? last_tick(speed) : term_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) term_q <= tick_t'(TICK_CNT - 1);
      else     term_q <= term_d;
   end

   assign term = term_q;
`else
   assign term = tick_t'(TICK_CNT - 1);
`endif

   // dir_q = 1 means the ping-pong bit travels toward the MSB
   always_comb begin
      nxt_led = mode_q == MODE_ROT_L ? {led_q[N_LEDS-2:0], led_q[N_LEDS-1]} :
                mode_q == MODE_ROT_R ? {led_q[0], led_q[N_LEDS-1:1]} :
                mode_q == MODE_PING  ? (dir_q ? led_q << 1 : led_q >> 1) :
                led_q == '0          ? N_LEDS'(1) :
                {led_q[N_LEDS-2:0], led_q[0] & ~(&led_q)};
      nxt_dir = dir_q ? ~led_q[N_LEDS-2] : led_q[1];
   end

   always_comb begin
      mode_in = mode_e'(mode);
      step    = state_q == ST_RUN && tick_q == term;
      state_d = state_q;
      tick_d  = tick_q;
      led_d   = led_q;
      mode_d  = mode_q;
      dir_d   = dir_q;
      unique case (state_q)
         ST_IDLE: begin
            mode_d  = mode_in;
            led_d   = init_pat(mode_in);
            dir_d   = 1'b1;
            tick_d  = '0;
            state_d = press ? ST_RUN : ST_IDLE;
         end
         ST_RUN: begin
            tick_d = step ? '0 : tick_q + 1'b1;
            if (step) begin
               mode_d = mode_in;
               led_d  = mode_in != mode_q ? init_pat(mode_in) : nxt_led;
               dir_d  = mode_in != mode_q ? 1'b1 : nxt_dir;
            end
            state_d = press ? ST_PAUSE : ST_RUN;
         end
         ST_PAUSE: state_d = press ? ST_RUN : ST_PAUSE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         tick_q  <= '0;
         led_q   <= '1;
         mode_q  <= MODE_ROT_L;
         dir_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         led_q   <= led_d;
         mode_q  <= mode_d;
         dir_q   <= dir_d;
      end
   end

   assign led  = led_q;
   assign busy = state_q == ST_RUN;

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb_led_pattern_engine: directed plus randomized stimulus against a step-index reference model.
module tb_led_pattern_engine;

   localparam int N    = 8;
   localparam int TICK = 4;
   localparam int DB   = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         button = 1'b0;
   logic [1:0]   mode = 2'd0;
   logic [N-1:0] led;
   logic         busy;

   int checks = 0;
   int failures = 0;

   typedef enum {M_IDLE, M_RUN, M_PAUSE} mstate_e;
   mstate_e ms = M_IDLE;
   bit      fresh = 1'b1;
   int      am = 0;
   int      idx = 0;
   int      tk = 0;
   int      hi_run = 0;

   led_pattern_engine #(.N_LEDS(N), .TICK_CNT(TICK), .DB_CNT(DB)) dut (
      .clk    (clk),
      .rst    (rst),
      .button (button),
      .mode   (mode),
`ifdef LED_PATTERN_SPEED_SEL_EN
      .speed  (2'd0),
`endif
      .led    (led),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
      end
   endtask

   // LED image of step i of pattern m, straight from the pattern definitions
   function automatic logic [N-1:0] pat(int m, int i);
      int p;
      case (m)
         0: return N'(1 << (i % N));
         1: return N'(1 << (N - 1 - i % N));
         2: begin
            p = i % (2*N - 2);
            return N'(1 << (p < N ? p : 2*N - 2 - p));
         end
         default: begin
            p = i % (2*N);
            return p < N ? N'((1 << (p + 1)) - 1) : N'(((1 << N) - 1) << (p - N + 1));
         end
      endcase
   endfunction

   // a press lands once the held level has crossed the synchroniser, the debounce window and the pulse register
   task automatic model_step();
      bit pr;
      if (rst) return;
      fresh  = 1'b0;
      hi_run = button ? hi_run + 1 : 0;
      pr     = hi_run == DB + 3;
      case (ms)
         M_IDLE: begin
            am  = int'(mode);
            idx = 0;
            tk  = 0;
            if (pr) ms = M_RUN;
         end
         M_RUN: begin
            if (tk == TICK - 1) begin
               tk = 0;
               if (int'(mode) != am) begin
                  am  = int'(mode);
                  idx = 0;
               end else idx++;
            end else tk++;
            if (pr) ms = M_PAUSE;
         end
         default: if (pr) ms = M_RUN;
      endcase
   endtask

   task automatic model_reset();
      ms     = M_IDLE;
      fresh  = 1'b1;
      am     = 0;
      idx    = 0;
      tk     = 0;
      hi_run = 0;
   endtask

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         chk("led", 32'(led), 32'(fresh ? {N{1'b1}} : pat(am, idx)));
         chk("busy", 32'(busy), 32'(ms == M_RUN));
      end
   endtask

   task automatic press(input int hold, input int low);
      button = 1'b1;
      cyc(hold);
      button = 1'b0;
      cyc(low);
   endtask

   task automatic async_reset(input int n);
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("rst_led", 32'(led), 32'(8'hFF));
      chk("rst_busy", 32'(busy), 32'(1'b0));
      cyc(n);
      rst = 1'b0;
      cyc(1);
   endtask

   initial begin
      model_reset();
      cyc(3);
      rst = 1'b0;
      cyc(50);
      press(20, 20);
      cyc(40);
      repeat (3) begin
         button = 1'b1;
         cyc(1);
         button = 1'b0;
         cyc(9);
      end
      mode = 2'd2;
      cyc(70);
      mode = 2'd3;
      cyc(80);
      press(10, 40);
      press(10, 20);
      mode = 2'd0;
      cyc(30);
      mode = 2'd1;
      cyc(16);
      async_reset(2);
      repeat (200) begin
         case ($urandom_range(0, 9))
            0, 1, 2: cyc($urandom_range(1, 30));
            3, 4:    begin mode = 2'($urandom_range(0, 3)); cyc($urandom_range(1, 12)); end
            5, 6:    press($urandom_range(8, 20), $urandom_range(8, 20));
            7:       begin button = 1'b1; cyc(1); button = 1'b0; cyc($urandom_range(8, 12)); end
            8:       async_reset($urandom_range(1, 3));
            default: cyc(TICK * $urandom_range(1, 8));
         endcase
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
